// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared types, constants and helpers for the demux_stream_ctrl slice.
//   state_t    : holding-stage occupancy (EMPTY / FULL)
//   MODE_ADDR  : destination taken from the in_sel field
//   MODE_RR    : destination taken from the round-robin pointer
//   onehot()   : select index -> one-hot vector (MAX_OUT bits wide; callers
//                truncate to their own channel count)
// ----------------------------------------------------------------------------
package demux_pkg;

   localparam int MAX_OUT   = 16;
   localparam int SEL_MAX_W = 4;

   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_RR   = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Decodes a channel index into a one-hot vector sized for the widest
   // supported demux, so a single helper serves every N_OUT.
   function automatic logic [MAX_OUT-1:0] onehot(input logic [SEL_MAX_W-1:0] sel);
      return MAX_OUT'(1) << sel;
   endfunction

endpackage

// File: rtl/demux_stream_ctrl_rr_pointer.sv
// ----------------------------------------------------------------------------
// rr_pointer
// Mod-N_OUT wrapping counter used as the round-robin destination pointer.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, pointer returns to 0
//   i_advance : step the pointer by one on this edge
//   o_ptr     : current pointer value (registered)
// ----------------------------------------------------------------------------
module rr_pointer #(
   parameter int N_OUT = 4,
   parameter int SELW  = $clog2(N_OUT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_advance,
   output logic [SELW-1:0] o_ptr
);

   logic [SELW-1:0] r_ptr;

   // The pointer only moves when asked; it wraps explicitly at N_OUT-1 so a
   // non-power-of-two channel count never produces an unused index.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_advance) begin
         if (r_ptr == SELW'(N_OUT - 1)) begin
            r_ptr <= '0;
         end else begin
            r_ptr <= r_ptr + SELW'(1);
         end
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/demux_stream_ctrl.sv
// ----------------------------------------------------------------------------
// demux_stream_ctrl
// 1-to-N_OUT stream demultiplexer with a single registered holding stage.
// Each accepted beat is steered to one channel, chosen either from in_sel
// (addressed mode) or from a round-robin pointer.
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : producer has a beat
//   in_ready   : beat accepted this cycle (combinational from out_ready)
//   in_data    : beat payload
//   in_sel     : destination index in addressed mode
//   mode       : 0 = addressed, 1 = round-robin
//   out_valid  : one-hot per-channel valid
//   out_data   : payload shared by all channels
//   out_ready  : per-channel ready
//   cur_sel    : destination of the held beat (0 when empty)
//   rr_ptr     : next round-robin destination
//   err_cnt    : saturating count of beats dropped for an illegal in_sel
// ----------------------------------------------------------------------------
module demux_stream_ctrl
   import demux_pkg::*;
#(
   parameter int N_OUT = 4,
   parameter int DW    = 8,
   parameter int SELW  = $clog2(N_OUT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   input  logic [SELW-1:0]  in_sel,
   input  logic             mode,
   output logic [N_OUT-1:0] out_valid,
   output logic [DW-1:0]    out_data,
   input  logic [N_OUT-1:0] out_ready,
   output logic [SELW-1:0]  cur_sel,
   output logic [SELW-1:0]  rr_ptr,
   output logic [7:0]       err_cnt
);

   state_t           r_state;
   logic [SELW-1:0]  r_curSel;
   logic [DW-1:0]    r_data;
   logic [N_OUT-1:0] r_outValid;
   logic [7:0]       r_errCnt;

   logic             w_outXfer;
   logic             w_inReady;
   logic             w_accept;
   logic             w_illegal;
   logic             w_load;
   logic             w_rrAdvance;
   logic [SELW-1:0]  w_rrPtr;
   logic [SELW-1:0]  w_dest;
   logic [N_OUT-1:0] w_destOh;

   // Handshake and destination decode. Because out_valid is one-hot on the
   // held destination, ANDing it with out_ready picks out exactly the selected
   // channel's ready and ignores every other consumer.
   always_comb begin
      w_outXfer   = |(r_outValid & out_ready);
      w_inReady   = (r_state == EMPTY) || w_outXfer;
      w_accept    = in_valid && w_inReady;
      w_illegal   = (mode == MODE_ADDR) && (32'(in_sel) >= N_OUT);
      w_load      = w_accept && !w_illegal;
      w_rrAdvance = w_accept && (mode == MODE_RR);
      w_dest      = (mode == MODE_RR) ? w_rrPtr : in_sel;
      w_destOh    = N_OUT'(onehot(SEL_MAX_W'(w_dest)));
   end

   rr_pointer #(
      .N_OUT (N_OUT),
      .SELW  (SELW)
   ) u_rrPointer (
      .clk       (clk),
      .rst       (rst),
      .i_advance (w_rrAdvance),
      .o_ptr     (w_rrPtr)
   );

   // Holding-stage FSM. A fresh load wins over a drain, which gives
   // back-to-back reloads (including a change of destination) with no empty
   // bubble. A beat with an illegal select is taken off the producer but never
   // loaded, so the state then behaves exactly as if nothing had arrived.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= EMPTY;
         r_curSel   <= '0;
         r_data     <= '0;
         r_outValid <= '0;
      end else if (w_load) begin
         r_state    <= FULL;
         r_curSel   <= w_dest;
         r_data     <= in_data;
         r_outValid <= w_destOh;
      end else if (w_outXfer) begin
         r_state    <= EMPTY;
         r_curSel   <= '0;
         r_data     <= '0;
         r_outValid <= '0;
      end
   end

   // Dropped-beat counter; sticks at 255 rather than wrapping so a long
   // storm of bad selects is still visible afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_errCnt <= '0;
      end else if (w_accept && w_illegal && (r_errCnt != 8'hFF)) begin
         r_errCnt <= r_errCnt + 8'd1;
      end
   end

   assign in_ready  = w_inReady;
   assign out_valid = r_outValid;
   assign out_data  = r_data;
   assign cur_sel   = r_curSel;
   assign rr_ptr    = w_rrPtr;
   assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_demux_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_demux_stream_ctrl
// Drives a 4-channel and a 3-channel demux_stream_ctrl side by side and
// compares both against a cycle-level behavioural model of the handshake.
// ----------------------------------------------------------------------------
module tb_demux_stream_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // Instance A: four channels
   logic       aInValid, aInReady, aMode;
   logic [7:0] aInData, aOutData, aErrCnt;
   logic [1:0] aInSel, aCurSel, aRrPtr;
   logic [3:0] aOutValid, aOutReady;

   // Instance B: three channels, so in_sel = 3 is an illegal destination
   logic       bInValid, bInReady, bMode;
   logic [7:0] bInData, bOutData, bErrCnt;
   logic [1:0] bInSel, bCurSel, bRrPtr;
   logic [2:0] bOutValid, bOutReady;

   demux_stream_ctrl #(.N_OUT(4), .DW(8)) dutA (
      .clk(clk), .rst(rst),
      .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
      .in_sel(aInSel), .mode(aMode),
      .out_valid(aOutValid), .out_data(aOutData), .out_ready(aOutReady),
      .cur_sel(aCurSel), .rr_ptr(aRrPtr), .err_cnt(aErrCnt)
   );

   demux_stream_ctrl #(.N_OUT(3), .DW(8)) dutB (
      .clk(clk), .rst(rst),
      .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
      .in_sel(bInSel), .mode(bMode),
      .out_valid(bOutValid), .out_data(bOutData), .out_ready(bOutReady),
      .cur_sel(bCurSel), .rr_ptr(bRrPtr), .err_cnt(bErrCnt)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural model state, index 0 = instance A, 1 = instance B
   int mN[2]    = '{4, 3};
   bit mHeld[2];
   int mDest[2];
   int mData[2];
   int mRr[2];
   int mErr[2];

   // Single comparison point; 4-state compare so X/Z on an output fails.
   task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // The producer may hand over a beat whenever nothing is held, or when the
   // held beat's own consumer takes it this cycle.
   function automatic bit modelReady(input int i, input logic [3:0] ordy);
      return !mHeld[i] || (ordy[mDest[i]] == 1'b1);
   endfunction

   task automatic resetModel();
      for (int i = 0; i < 2; i++) begin
         mHeld[i] = 0; mDest[i] = 0; mData[i] = 0; mRr[i] = 0; mErr[i] = 0;
      end
   endtask

   // One clock edge worth of transfer rules for instance i.
   task automatic modelStep(input int i, input logic v, input int data, input int sel,
                            input logic md, input logic [3:0] ordy);
      bit drained, taken, dropped;
      int dest;
      drained = mHeld[i] && (ordy[mDest[i]] == 1'b1);
      taken   = v && modelReady(i, ordy);
      dropped = 0;
      dest    = sel;
      if (taken && md) begin
         dest   = mRr[i];
         mRr[i] = (mRr[i] + 1) % mN[i];
      end
      if (taken && !md && sel >= mN[i]) begin
         dropped = 1;
         mErr[i] = (mErr[i] < 255) ? mErr[i] + 1 : 255;
      end
      if (taken && !dropped) begin
         mHeld[i] = 1; mDest[i] = dest; mData[i] = data;
      end else if (drained) begin
         mHeld[i] = 0; mDest[i] = 0; mData[i] = 0;
      end
   endtask

   task automatic checkOutput();
      checkEq("aOutValid", aOutValid, mHeld[0] ? (1 << mDest[0]) : 0);
      checkEq("aOutData",  aOutData,  mData[0]);
      checkEq("aCurSel",   aCurSel,   mDest[0]);
      checkEq("aRrPtr",    aRrPtr,    mRr[0]);
      checkEq("aErrCnt",   aErrCnt,   mErr[0]);
      checkEq("bOutValid", bOutValid, mHeld[1] ? (1 << mDest[1]) : 0);
      checkEq("bOutData",  bOutData,  mData[1]);
      checkEq("bCurSel",   bCurSel,   mDest[1]);
      checkEq("bRrPtr",    bRrPtr,    mRr[1]);
      checkEq("bErrCnt",   bErrCnt,   mErr[1]);
   endtask

   // Called just after a falling edge with inputs already set: checks the
   // combinational in_ready, advances the model, crosses the rising edge and
   // checks all registered outputs on the following falling edge.
   task automatic applyStimulus();
      #1;
      if (!rst) begin
         checkEq("aInReady", aInReady, modelReady(0, aOutReady));
         checkEq("bInReady", bInReady, modelReady(1, {1'b0, bOutReady}));
         modelStep(0, aInValid, aInData, aInSel, aMode, aOutReady);
         modelStep(1, bInValid, bInData, bInSel, bMode, {1'b0, bOutReady});
      end else begin
         resetModel();
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   int rrExpect[6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      rst = 1'b1;
      aInValid = 0; aInData = 0; aInSel = 0; aMode = 0; aOutReady = 0;
      bInValid = 0; bInData = 0; bInSel = 0; bMode = 0; bOutReady = 0;
      resetModel();
      @(negedge clk);
      applyStimulus();
      rst = 1'b0;
      checkEq("resetInReady", aInReady, 1);

      // Addressed beat to channel 2
      aMode = 0; aInSel = 2; aInData = 8'hA5; aOutReady = 4'hF; aInValid = 1;
      applyStimulus();
      checkEq("addrValid", aOutValid, 4'b0100);
      checkEq("addrData", aOutData, 8'hA5);
      checkEq("addrReady", aInReady, 1);
      aInValid = 0;
      applyStimulus();

      // Round-robin burst, one beat per cycle
      aMode = 1; aInValid = 1;
      for (int k = 0; k < 6; k++) begin
         aInData = 8'(8'h10 + k);
         applyStimulus();
         checkEq("rrDest", aCurSel, rrExpect[k]);
         checkEq("rrData", aOutData, 8'(8'h10 + k));
      end
      checkEq("rrPtrAfter", aRrPtr, 2);
      aInValid = 0;
      applyStimulus();

      // Backpressure on channel 1 while channel 0 is ready
      aMode = 0; aInSel = 1; aInData = 8'h3C; aOutReady = 4'b0001; aInValid = 1;
      applyStimulus();
      aInSel = 2; aInData = 8'h77;
      for (int k = 0; k < 3; k++) begin
         applyStimulus();
         checkEq("bpReady", aInReady, 0);
         checkEq("bpValid", aOutValid, 4'b0010);
         checkEq("bpData", aOutData, 8'h3C);
      end
      aOutReady = 4'b0011;
      applyStimulus();
      checkEq("bpReload", aOutValid, 4'b0100);
      checkEq("bpReloadData", aOutData, 8'h77);

      // Back-to-back destination switch 3 -> 0
      aOutReady = 4'hF; aInSel = 3; aInData = 8'h81;
      applyStimulus();
      checkEq("b2bFirst", aOutValid, 4'b1000);
      aInSel = 0; aInData = 8'h82;
      applyStimulus();
      checkEq("b2bSecond", aOutValid, 4'b0001);
      aInValid = 0;
      applyStimulus();

      // Illegal select storm on the three-channel instance
      bMode = 0; bInSel = 3; bOutReady = 3'b111; bInValid = 1;
      for (int k = 0; k < 257; k++) begin
         bInData = 8'(k);
         applyStimulus();
         checkEq("illValid", bOutValid, 0);
      end
      checkEq("illErrSat", bErrCnt, 255);
      bInValid = 0;

      // Randomized traffic on both instances with occasional resets
      for (int k = 0; k < 600; k++) begin
         rst       = ($urandom_range(0, 59) == 0);
         aInValid  = 1'($urandom_range(0, 3) != 0);
         aInData   = 8'($urandom);
         aInSel    = 2'($urandom);
         aMode     = 1'($urandom);
         aOutReady = 4'($urandom);
         bInValid  = 1'($urandom_range(0, 3) != 0);
         bInData   = 8'($urandom);
         bInSel    = 2'($urandom_range(0, 3));
         bMode     = 1'($urandom);
         bOutReady = 3'($urandom);
         applyStimulus();
      end
      rst = 0;
      bInValid = 0;

      // Reset while FULL with the pointer at 2
      rst = 1;
      applyStimulus();
      rst = 0;
      aMode = 1; aOutReady = 4'hF; aInValid = 1; aInData = 8'h55;
      applyStimulus();
      applyStimulus();
      aInValid = 0; aOutReady = 4'h0;
      applyStimulus();
      checkEq("preRstValid", aOutValid, 4'b0010);
      checkEq("preRstPtr", aRrPtr, 2);
      rst = 1;
      applyStimulus();
      rst = 0;
      checkEq("rstValid", aOutValid, 0);
      checkEq("rstPtr", aRrPtr, 0);
      checkEq("rstErr", bErrCnt, 0);
      #1;
      checkEq("rstReady", aInReady, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
